// File: rtl/ts_surface_mem_responder.sv
// Timestamp-surface memory responder: dual-port read / port-1 write access to a
// DVS_WIDTH x DVS_HEIGHT word surface, zero-filled by a sweep after reset or clear_req.
module ts_surface_mem_responder #(
    parameter int unsigned DVS_WIDTH       = 346,
    parameter int unsigned DVS_HEIGHT      = 260,
    parameter int unsigned WORD_SIZE       = 18,
    parameter int unsigned CAVIAR_X_Y_BITS = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cen,
    input  logic                       rw,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_x,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_y,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_x,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_y,
    input  logic [WORD_SIZE-1:0]       write_data_mem,
    input  logic                       clear_req,
    output logic [WORD_SIZE-1:0]       read_data1_mem,
    output logic [WORD_SIZE-1:0]       read_data2_mem,
    output logic                       read_data_mem_vld1,
    output logic                       read_data_mem_vld2,
    output logic                       ready,
    output logic                       o_dbg_state
);

    localparam int unsigned DEPTH  = DVS_WIDTH * DVS_HEIGHT;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LIN_W  = CAVIAR_X_Y_BITS + $clog2(DVS_WIDTH + 1) + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [WORD_SIZE-1:0] r_mem [DEPTH];

    logic [LIN_W-1:0]     w_lin1;
    logic [LIN_W-1:0]     w_lin2;
    logic                 w_in1;
    logic                 w_in2;
    logic [ADDR_W-1:0]    w_idx1;
    logic [ADDR_W-1:0]    w_idx2;
    logic [WORD_SIZE-1:0] w_rd1;
    logic [WORD_SIZE-1:0] w_rd2;
    logic                 w_accept;
    logic                 w_if_rd;
    logic                 w_if_wr;

    // Linear address is formed wide enough that an out-of-sensor coordinate can never alias a valid word.
    assign w_lin1 = LIN_W'(addr_port1_y) * LIN_W'(DVS_WIDTH) + LIN_W'(addr_port1_x);
    assign w_lin2 = LIN_W'(addr_port2_y) * LIN_W'(DVS_WIDTH) + LIN_W'(addr_port2_x);

    assign w_in1 = (32'(addr_port1_x) < DVS_WIDTH) && (32'(addr_port1_y) < DVS_HEIGHT)
                   && (w_lin1 < LIN_W'(DEPTH));
    assign w_in2 = (32'(addr_port2_x) < DVS_WIDTH) && (32'(addr_port2_y) < DVS_HEIGHT)
                   && (w_lin2 < LIN_W'(DEPTH));

    assign w_idx1 = w_lin1[ADDR_W-1:0];
    assign w_idx2 = w_lin2[ADDR_W-1:0];

    // Neighbours outside the sensor read as zero ("never seen an event").
    assign w_rd1 = w_in1 ? r_mem[w_idx1] : '0;
    assign w_rd2 = w_in2 ? r_mem[w_idx2] : '0;

    // clear_req has priority over any request issued in the same cycle.
    assign w_accept = (r_state == S_READY) && cen && !clear_req;
    assign w_if_rd  = w_accept && !rw;
    assign w_if_wr  = w_accept && rw && w_in1;

    assign o_dbg_state = (r_state == S_READY);

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_if_wr) begin
            r_mem[w_idx1] <= write_data_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_CLEAR;
            r_cnt              <= '0;
            ready              <= 1'b0;
            read_data_mem_vld1 <= 1'b0;
            read_data_mem_vld2 <= 1'b0;
            read_data1_mem     <= '0;
            read_data2_mem     <= '0;
        end else begin
            read_data_mem_vld1 <= 1'b0;
            read_data_mem_vld2 <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    if (clear_req) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_READY;
                        ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (clear_req) begin
                        r_cnt   <= '0;
                        r_state <= S_CLEAR;
                        ready   <= 1'b0;
                    end else if (w_if_rd) begin
                        read_data_mem_vld1 <= 1'b1;
                        read_data_mem_vld2 <= 1'b1;
                        read_data1_mem     <= w_rd1;
                        read_data2_mem     <= w_rd2;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
